wb_scratch_responder: RTL and testbench

//  Wishbone B4 classic-cycle slave answering the tt04_to_wishbone master; the responder end of the bridge.

---
 rtl/wb_scratch_responder_pkg.sv | 8 +
 rtl/wb_scratch_ram.sv | 19 +
 rtl/wb_scratch_responder.sv | 96 +++++++++
 tb/tb_wb_scratch_responder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/wb_scratch_responder_pkg.sv
// wb_scratch_responder_pkg: register map indices, default ID and FSM state type
package wb_scratch_responder_pkg;
  localparam int REG_ID_IDX = 0;
  localparam int REG_TXN_IDX = 1;
  localparam int REG_RAM_BASE = 2;
  localparam logic [31:0] ID_DEFAULT = 32'h7504_B001;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
endpackage

// File: rtl/wb_scratch_ram.sv
// wb_scratch_ram: DEPTH x 32 flop array with byte-lane write and async read
module wb_scratch_ram #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [3:0]               sel,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);
  logic [31:0] mem [DEPTH];
  // clear on reset, otherwise update only the enabled byte lanes
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (we) for (int b = 0; b < 4; b++) if (sel[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
  assign rdata = mem[addr];
endmodule

// File: rtl/wb_scratch_responder.sv
// wb_scratch_responder: Wishbone classic slave with ID, transfer counter and scratch RAM
module wb_scratch_responder
  import wb_scratch_responder_pkg::*;
#(
  parameter int          ADDR_W      = 14,
  parameter int          DEPTH       = 16,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = ID_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_CYC,
  input  logic              wb_STB,
  input  logic              wb_WE,
  input  logic [ADDR_W-1:0] wb_ADR,
  input  logic [3:0]        wb_SEL,
  input  logic [31:0]       wb_DAT_MOSI,
  output logic [31:0]       wb_DAT_MISO,
  output logic              wb_ACK
);
  localparam int IW = ADDR_W - 2;
  localparam int AW = $clog2(DEPTH);
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic we_q;
  logic [IW-1:0] idx_q;
  logic [3:0] sel_q;
  logic [31:0] dat_q;
  logic [31:0] txn;
  logic [31:0] ram_rd;
  logic req, commit, r_we, is_id, is_txn, ram_hit;
  logic [IW-1:0] r_idx;
  logic [3:0] r_sel;
  logic [31:0] r_dat, rd_data;
  logic unused_adr;
  assign unused_adr = ^wb_ADR[1:0];
  assign req = wb_CYC & wb_STB;
  assign r_we = state == S_IDLE ? wb_WE : we_q;
  assign r_idx = state == S_IDLE ? wb_ADR[ADDR_W-1:2] : idx_q;
  assign r_sel = state == S_IDLE ? wb_SEL : sel_q;
  assign r_dat = state == S_IDLE ? wb_DAT_MOSI : dat_q;
  assign commit = state_n == S_ACK && state != S_ACK;
  assign is_id = r_idx == IW'(REG_ID_IDX);
  assign is_txn = r_idx == IW'(REG_TXN_IDX);
  assign ram_hit = r_idx >= IW'(REG_RAM_BASE) && r_idx < IW'(REG_RAM_BASE + DEPTH);
  assign rd_data = is_id ? ID_VALUE : is_txn ? txn : ram_hit ? ram_rd : '0;
  assign wb_ACK = state == S_ACK;
  // next state: accept in IDLE, count wait states, abort on CYC loss, single ACK cycle
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      S_IDLE: if (req) begin
        state_n = WAIT_STATES > 0 ? S_WAIT : S_ACK;
        cnt_n = 4'(WAIT_STATES - 1);
      end
      S_WAIT: begin
        state_n = !wb_CYC ? S_IDLE : cnt == 4'd0 ? S_ACK : S_WAIT;
        cnt_n = cnt - 4'd1;
      end
      default: state_n = S_IDLE;
    endcase
  end
  // state, request latches, counter and read data; effects commit on the edge entering ACK
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      we_q <= 1'b0;
      idx_q <= '0;
      sel_q <= '0;
      dat_q <= '0;
      txn <= '0;
      wb_DAT_MISO <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (state == S_IDLE && req) begin
        we_q <= wb_WE;
        idx_q <= wb_ADR[ADDR_W-1:2];
        sel_q <= wb_SEL;
        dat_q <= wb_DAT_MOSI;
      end
      if (commit) txn <= r_we && is_txn ? '0 : txn + 32'd1;
      if (commit && !r_we) wb_DAT_MISO <= rd_data;
    end
  wb_scratch_ram #(.DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .rst(rst),
    .we(commit & r_we & ram_hit),
    .addr(AW'(r_idx - IW'(REG_RAM_BASE))),
    .sel(r_sel),
    .wdata(r_dat),
    .rdata(ram_rd)
  );
endmodule

// File: tb/tb_wb_scratch_responder.sv
// tb_wb_scratch_responder: scoreboard bench over three instances (0, 1 and 3 wait states)
module tb_wb_scratch_responder;
  localparam logic [31:0] ID = 32'h7504_B001;
  logic clk = 0, rst = 0;
  logic cyc [3], stb [3], we [3], ack [3];
  logic [13:0] adr [3];
  logic [3:0] sel [3];
  logic [31:0] mosi [3], miso [3];
  typedef struct {int d; bit rd; logic [31:0] v;} exp_t;
  exp_t sb [$];
  logic [31:0] m_ram [3][16];
  logic [31:0] m_txn [3];
  int total = 0, pass = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    wb_scratch_responder #(.WAIT_STATES(g == 0 ? 0 : g == 1 ? 1 : 3)) dut (
      .clk(clk), .rst(rst), .wb_CYC(cyc[g]), .wb_STB(stb[g]), .wb_WE(we[g]),
      .wb_ADR(adr[g]), .wb_SEL(sel[g]), .wb_DAT_MOSI(mosi[g]),
      .wb_DAT_MISO(miso[g]), .wb_ACK(ack[g])
    );
  end

  function automatic int ws_of(int d);
    return d == 0 ? 0 : d == 1 ? 1 : 3;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] model(int d, bit w, logic [13:0] a, logic [3:0] s, logic [31:0] v);
    int idx;
    logic [31:0] r;
    idx = int'(a[13:2]);
    r = idx == 0 ? ID : idx == 1 ? m_txn[d] : (idx >= 2 && idx < 18) ? m_ram[d][idx-2] : 32'd0;
    if (w && idx >= 2 && idx < 18)
      for (int b = 0; b < 4; b++) if (s[b]) m_ram[d][idx-2][8*b +: 8] = v[8*b +: 8];
    m_txn[d] = (w && idx == 1) ? 32'd0 : m_txn[d] + 32'd1;
    return r;
  endfunction

  always @(negedge clk)
    if (!rst)
      for (int d = 0; d < 3; d++)
        if (ack[d]) begin
          if (sb.size() == 0) chk("unexpected_ack", 32'(d), 32'hFFFF_FFFF);
          else begin
            exp_t e;
            e = sb.pop_front();
            chk("ack_dut", 32'(d), 32'(e.d));
            if (e.rd) chk("read_data", miso[d], e.v);
          end
        end

  task automatic drive(int d, bit c, bit w, logic [13:0] a, logic [3:0] s, logic [31:0] v);
    cyc[d] = c; stb[d] = c; we[d] = w; adr[d] = a; sel[d] = s; mosi[d] = v;
  endtask

  task automatic xfer(int d, bit w, logic [13:0] a, logic [3:0] s, logic [31:0] v);
    exp_t e;
    int n;
    e.d = d; e.rd = !w; e.v = model(d, w, a, s, v);
    sb.push_back(e);
    drive(d, 1, w, a, s, v);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ack[d] && n < 20);
    chk("latency", 32'(n), 32'(ws_of(d) + 1));
    drive(d, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
  endtask

  task automatic reset_all();
    rst = 1;
    for (int d = 0; d < 3; d++) drive(d, 0, 0, 0, 0, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int d = 0; d < 3; d++) begin
      m_txn[d] = 0;
      for (int i = 0; i < 16; i++) m_ram[d][i] = 0;
      chk("reset_ack", 32'(ack[d]), 0);
      chk("reset_miso", miso[d], 0);
    end
  endtask

  initial begin
    bit seen;
    reset_all();
    // basic read of ID, then byte-lane merges and counter read
    xfer(1, 0, 14'h0000, 4'h0, 0);
    xfer(1, 1, 14'h0008, 4'hF, 32'hA5A5A5A5);
    xfer(1, 1, 14'h0008, 4'b0101, 32'h11223344);
    xfer(1, 0, 14'h0008, 4'h0, 0);
    xfer(1, 0, 14'h0004, 4'h0, 0);
    // last RAM word and first index past it
    xfer(1, 1, 14'h0044, 4'hF, 32'hCAFEF00D);
    xfer(1, 0, 14'h0048, 4'hF, 0);
    xfer(1, 0, 14'h0044, 4'h0, 0);
    xfer(1, 1, 14'h0000, 4'hF, 32'hFFFF_FFFF);
    xfer(1, 0, 14'h0000, 4'h0, 0);
    // randomized traffic over the whole map plus unmapped indices
    for (int i = 0; i < 80; i++)
      xfer(1, 1'($urandom_range(0, 1)), 14'({$urandom_range(0, 21), 2'b00}) | 14'($urandom_range(0, 3)),
           4'($urandom), $urandom);
    for (int i = 0; i < 16; i++) xfer(1, 0, 14'((i + 2) * 4), 4'h0, 0);
    // abort during wait states: no ACK, no write, no count
    xfer(2, 1, 14'h0010, 4'hF, 32'h0BAD_CAFE);
    drive(2, 1, 1, 14'h000C, 4'hF, 32'h12345678);
    repeat (2) begin @(posedge clk); #1; end
    drive(2, 0, 0, 0, 0, 0);
    seen = 0;
    repeat (6) begin @(posedge clk); #1; seen |= ack[2]; end
    chk("abort_no_ack", 32'(seen), 0);
    xfer(2, 0, 14'h000C, 4'h0, 0);
    xfer(2, 0, 14'h0004, 4'h0, 0);
    xfer(2, 0, 14'h0010, 4'h0, 0);
    // STB held through ACK with zero wait states repeats every other cycle
    void'(model(0, 0, 14'h0000, 4'h0, 0));
    void'(model(0, 0, 14'h0000, 4'h0, 0));
    sb.push_back('{0, 1'b1, ID});
    sb.push_back('{0, 1'b1, ID});
    drive(0, 1, 0, 14'h0000, 4'h0, 0);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      chk($sformatf("repeat_ack_%0d", e), 32'(ack[0]), 32'(e % 2));
    end
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    xfer(0, 0, 14'h0004, 4'h0, 0);
    xfer(0, 1, 14'h0004, 4'h0, 0);
    xfer(0, 0, 14'h0004, 4'h0, 0);
    // reset during the ACK cycle drops ACK immediately
    drive(0, 1, 1, 14'h0008, 4'hF, 32'h55AA55AA);
    @(posedge clk); #1;
    rst = 1; #1;
    chk("rst_ack_drop", 32'(ack[0]), 0);
    reset_all();
    // reset during WAIT of a write discards it
    xfer(1, 1, 14'h0020, 4'hF, 32'h01020304);
    drive(1, 1, 1, 14'h0020, 4'hF, 32'hDEADBEEF);
    @(posedge clk); #1;
    rst = 1; #1;
    chk("rst_wait_ack", 32'(ack[1]), 0);
    reset_all();
    xfer(1, 0, 14'h0020, 4'h0, 0);
    xfer(1, 0, 14'h0000, 4'h0, 0);
    xfer(1, 0, 14'h0004, 4'h0, 0);
    repeat (4) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
